// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size encodings, FSM states
// and the size-to-byte-count helper.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP
    } lsu_state_e;

    function automatic logic [3:0] bytes_of(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake between the execute stage and the LSU, and the
// 8-byte-window data-memory port driven by the LSU.
interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface lsu_mem_if;
    logic [63:0] mem_address;
    logic [63:0] Write_Data;
    logic        MemWrite;
    logic        MemRead;
    logic [63:0] Read_Data;

    modport master (
        output mem_address, Write_Data, MemWrite, MemRead,
        input  Read_Data
    );
    modport slave (
        input  mem_address, Write_Data, MemWrite, MemRead,
        output Read_Data
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Lane arithmetic on an 8-byte memory window: extracts and extends a load
// value, and merges store bytes into the window for read-modify-write.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [63:0] window,
    input  logic [2:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [63:0] wdata,
    output logic [63:0] load_data,
    output logic [63:0] store_window
);

    logic [63:0] shifted;
    logic [63:0] size_mask;
    logic [63:0] lane_mask;

    always_comb begin
        shifted = window >> {lane, 3'b000};
        case (size)
            SZ_B: begin
                load_data = {{56{~is_unsigned & shifted[7]}}, shifted[7:0]};
                size_mask = 64'h0000_0000_0000_00FF;
            end
            SZ_H: begin
                load_data = {{48{~is_unsigned & shifted[15]}}, shifted[15:0]};
                size_mask = 64'h0000_0000_0000_FFFF;
            end
            SZ_W: begin
                load_data = {{32{~is_unsigned & shifted[31]}}, shifted[31:0]};
                size_mask = 64'h0000_0000_FFFF_FFFF;
            end
            default: begin
                load_data = shifted;
                size_mask = '1;
            end
        endcase
        // Bytes outside the addressed lanes are written back exactly as read.
        lane_mask    = size_mask << {lane, 3'b000};
        store_window = (window & ~lane_mask) | ((wdata << {lane, 3'b000}) & lane_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// CPU-side load/store unit: one request at a time, sub-double stores done as
// read-modify-write on the memory's fixed 8-byte window.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 100
) (
    input  logic        clk,
    input  logic        reset_n,
    lsu_req_if.slave    req,
    lsu_mem_if.master   mem
);

    localparam logic [63:0] BASE_MAX = 64'(MEM_BYTES - 8);
    localparam logic [64:0] MEM_LIM  = 65'(MEM_BYTES);

    lsu_state_e  state_q;
    logic        resp_valid_q;
    logic [63:0] resp_rdata_q;
    logic        resp_err_q;
    logic        mem_rd_q;
    logic        mem_wr_q;
    logic [63:0] mem_addr_q;
    logic [63:0] wr_data_q;

    logic [1:0]  size_q;
    logic        uns_q;
    logic [2:0]  lane_q;
    logic [63:0] wdata_q;

    logic [3:0]  nb;
    logic        req_err;
    logic [63:0] base;
    logic [2:0]  lane;
    logic [63:0] load_data;
    logic [63:0] store_window;

    // Window is clamped so it never reaches past the last implemented byte.
    always_comb begin
        nb      = bytes_of(req.req_size);
        req_err = ((req.req_addr & (64'(nb) - 64'd1)) != 64'd0) ||
                  (({1'b0, req.req_addr} + 65'(nb)) > MEM_LIM);
        base    = (req.req_addr < BASE_MAX) ? req.req_addr : BASE_MAX;
        lane    = req.req_addr[2:0] - base[2:0];
    end

    lsu_lane_align u_align (
        .window       (mem.Read_Data),
        .lane         (lane_q),
        .size         (size_q),
        .is_unsigned  (uns_q),
        .wdata        (wdata_q),
        .load_data    (load_data),
        .store_window (store_window)
    );

    always_ff @(posedge clk) begin
        if (state_q == IDLE && req.req_valid) begin
            size_q  <= req.req_size;
            uns_q   <= req.req_unsigned;
            lane_q  <= lane;
            wdata_q <= req.req_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            wr_data_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req.req_valid) begin
                        mem_addr_q <= base;
                        if (req_err) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (!req.req_write) begin
                            state_q  <= LOAD;
                            mem_rd_q <= 1'b1;
                        end else if (req.req_size == SZ_D) begin
                            state_q   <= WRITE;
                            wr_data_q <= req.req_wdata;
                            mem_wr_q  <= 1'b1;
                        end else begin
                            state_q  <= RMW_RD;
                            mem_rd_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    state_q      <= RESP;
                    mem_rd_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= load_data;
                end
                RMW_RD: begin
                    state_q   <= WRITE;
                    mem_rd_q  <= 1'b0;
                    wr_data_q <= store_window;
                    mem_wr_q  <= 1'b1;
                end
                WRITE: begin
                    state_q      <= RESP;
                    mem_wr_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req.req_ready   = (state_q == IDLE) && reset_n;
    assign req.resp_valid  = resp_valid_q;
    assign req.resp_rdata  = resp_rdata_q;
    assign req.resp_err    = resp_err_q;
    assign mem.mem_address = mem_addr_q;
    assign mem.Write_Data  = wr_data_q;
    assign mem.MemRead     = mem_rd_q;
    assign mem.MemWrite    = mem_wr_q;

endmodule
